// File: rtl/spmm_pkg.sv
// spmm_pkg: shared comparator codes, intersect FSM states and default widths for the SpMM datapath
package spmm_pkg;
  localparam int DATA_WIDTH_DEF = 4;
  localparam int POS_WIDTH_DEF = 8;
  localparam logic [1:0] COMP_LT = 2'b00;
  localparam logic [1:0] COMP_EQ = 2'b01;
  localparam logic [1:0] COMP_GT = 2'b10;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN_A, DRAIN_B, FLUSH} isect_state_t;
endpackage

// File: rtl/comparator.sv
// comparator: orders d0 against d1_ref as LT/EQ/GT code
module comparator
  import spmm_pkg::*;
#(
  parameter int data_width_param = DATA_WIDTH_DEF
) (
  input  logic [data_width_param-1:0] d0,
  input  logic [data_width_param-1:0] d1_ref,
  output logic [1:0]                  comparator_out
);
  assign comparator_out = (d0 < d1_ref) ? COMP_LT : (d0 == d1_ref) ? COMP_EQ : COMP_GT;
endmodule

// File: rtl/index_intersect_ctrl.sv
// index_intersect_ctrl: merges two sorted index streams and emits matching indices with their positions
module index_intersect_ctrl
  import spmm_pkg::*;
#(
  parameter int data_width_param = DATA_WIDTH_DEF,
  parameter int pos_width_param  = POS_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [data_width_param-1:0] a_idx,
  input  logic                        a_last,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [data_width_param-1:0] b_idx,
  input  logic                        b_last,
  output logic                        match_valid,
  input  logic                        match_ready,
  output logic [data_width_param-1:0] match_idx,
  output logic [pos_width_param-1:0]  match_pos_a,
  output logic [pos_width_param-1:0]  match_pos_b,
  output logic [pos_width_param-1:0]  match_count,
  output logic                        busy,
  output logic                        done
);
  localparam logic [pos_width_param-1:0] one = 1;
  isect_state_t state_q, state_d;
  logic [pos_width_param-1:0] pos_a_q, pos_a_d, pos_b_q, pos_b_d, cnt_q, cnt_d, mpa_q, mpa_d, mpb_q, mpb_d;
  logic [data_width_param-1:0] midx_q, midx_d;
  logic mv_q, mv_d;
  logic [1:0] cmp;
  comparator #(.data_width_param(data_width_param)) u_cmp (
    .d0(a_idx),
    .d1_ref(b_idx),
    .comparator_out(cmp)
  );
  always_comb begin
    state_d = state_q;
    pos_a_d = pos_a_q;
    pos_b_d = pos_b_q;
    cnt_d   = cnt_q;
    mv_d    = mv_q && !match_ready;
    midx_d  = midx_q;
    mpa_d   = mpa_q;
    mpb_d   = mpb_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        pos_a_d = '0;
        pos_b_d = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: if (a_valid && b_valid) begin
        if (cmp == COMP_LT) begin
          a_ready = 1'b1;
          pos_a_d = pos_a_q + one;
          state_d = a_last ? DRAIN_B : RUN;
        end else if (cmp == COMP_GT) begin
          b_ready = 1'b1;
          pos_b_d = pos_b_q + one;
          state_d = b_last ? DRAIN_A : RUN;
        end else if (!mv_q || match_ready) begin
          // a new load wins over the downstream pop of the previous match
          a_ready = 1'b1;
          b_ready = 1'b1;
          mv_d    = 1'b1;
          midx_d  = a_idx;
          mpa_d   = pos_a_q;
          mpb_d   = pos_b_q;
          pos_a_d = pos_a_q + one;
          pos_b_d = pos_b_q + one;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + one;
          state_d = (a_last && b_last) ? FLUSH : a_last ? DRAIN_B : b_last ? DRAIN_A : RUN;
        end
      end
      DRAIN_A: begin
        a_ready = a_valid;
        if (a_valid) begin
          pos_a_d = pos_a_q + one;
          state_d = a_last ? FLUSH : DRAIN_A;
        end
      end
      DRAIN_B: begin
        b_ready = b_valid;
        if (b_valid) begin
          pos_b_d = pos_b_q + one;
          state_d = b_last ? FLUSH : DRAIN_B;
        end
      end
      FLUSH: state_d = mv_q ? FLUSH : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_a_q <= '0;
      pos_b_q <= '0;
      cnt_q   <= '0;
      mv_q    <= 1'b0;
      midx_q  <= '0;
      mpa_q   <= '0;
      mpb_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_a_q <= pos_a_d;
      pos_b_q <= pos_b_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
      midx_q  <= midx_d;
      mpa_q   <= mpa_d;
      mpb_q   <= mpb_d;
    end
  end
  assign match_valid = mv_q;
  assign match_idx   = midx_q;
  assign match_pos_a = mpa_q;
  assign match_pos_b = mpb_q;
  assign match_count = cnt_q;
  assign busy        = state_q != IDLE;
  assign done        = (state_q == FLUSH) && !mv_q;
endmodule

// File: tb/tb_index_intersect_ctrl.sv
// tb_index_intersect_ctrl: directed stream runs with a match scoreboard and decoupled monitor
module tb_index_intersect_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0, match_ready = 1'b1;
  logic [3:0] a_idx = '0, b_idx = '0;
  logic a_ready, b_ready, match_valid, busy, done;
  logic [3:0] match_idx;
  logic [7:0] match_pos_a, match_pos_b, match_count;
  int checks = 0, errors = 0, done_cnt = 0;
  int a_q[$], b_q[$];
  logic [19:0] exp_q[$];
  logic [19:0] e, held;
  logic held_v = 1'b0;

  index_intersect_ctrl #(.data_width_param(4), .pos_width_param(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_last(b_last),
    .match_valid(match_valid), .match_ready(match_ready), .match_idx(match_idx),
    .match_pos_a(match_pos_a), .match_pos_b(match_pos_b), .match_count(match_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // upstream model: heads change only after a posedge, consumed heads popped at the prior negedge
  always @(posedge clk) begin
    #2;
    a_valid = a_q.size() > 0;
    a_idx   = a_valid ? 4'(a_q[0]) : 4'd0;
    a_last  = a_q.size() == 1;
    b_valid = b_q.size() > 0;
    b_idx   = b_valid ? 4'(b_q[0]) : 4'd0;
    b_last  = b_q.size() == 1;
  end

  always @(negedge clk) begin
    if (rst_n && a_valid && a_ready) void'(a_q.pop_front());
    if (rst_n && b_valid && b_ready) void'(b_q.pop_front());
  end

  always @(negedge clk) begin
    if (rst_n && held_v && match_valid)
      chk("hold_stable", int'({match_idx, match_pos_a, match_pos_b}), int'(held));
    held_v = rst_n && match_valid && !match_ready;
    held   = {match_idx, match_pos_a, match_pos_b};
    if (rst_n && match_valid && match_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_match: got idx %0d expected none", match_idx);
      end else begin
        e = exp_q.pop_front();
        chk("match_idx", int'(match_idx), int'(e[19:16]));
        chk("match_pos_a", int'(match_pos_a), int'(e[15:8]));
        chk("match_pos_b", int'(match_pos_b), int'(e[7:0]));
      end
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    done_cnt = 0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_match(input int idx, input int pa, input int pb);
    exp_q.push_back({4'(idx), 8'(pa), 8'(pb)});
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!match_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(match_valid), 1);
  endtask

  task automatic finish_run(input string name, input int cnt);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_count"}, int'(match_count), cnt);
    chk({name, "_exp_left"}, exp_q.size(), 0);
    chk({name, "_streams_left"}, a_q.size() + b_q.size(), 0);
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", int'(match_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(match_count), 0);
    chk("rst_readies", int'({a_ready, b_ready}), 0);
    step();
    rst_n = 1'b1;

    a_q = '{1, 3, 5, 9};
    b_q = '{3, 4, 9, 11};
    expect_match(3, 1, 0);
    expect_match(9, 3, 2);
    pulse_start();
    finish_run("basic", 2);

    a_q = '{0, 2};
    b_q = '{8, 15};
    pulse_start();
    finish_run("disjoint", 0);

    a_q = '{11, 15};
    b_q = '{11, 15};
    expect_match(11, 0, 0);
    expect_match(15, 1, 1);
    match_ready = 1'b0;
    pulse_start();
    wait_valid("bp_first_valid");
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_idx_held", int'(match_idx), 11);
      chk("bp_readies_low", int'({a_ready, b_ready}), 0);
    end
    step();
    match_ready = 1'b1;
    finish_run("backpressure", 2);

    a_q = '{9};
    b_q = '{9};
    expect_match(9, 0, 0);
    match_ready = 1'b0;
    pulse_start();
    wait_valid("simlast_valid");
    repeat (2) @(negedge clk);
    chk("simlast_no_early_done", done_cnt, 0);
    step();
    match_ready = 1'b1;
    finish_run("simlast", 1);

    a_q = '{2, 7, 9};
    b_q = '{7, 9};
    match_ready = 1'b0;
    pulse_start();
    wait_valid("rst_mid_valid");
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("rstmid_valid", int'(match_valid), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_readies", int'({a_ready, b_ready}), 0);
    chk("rstmid_count", int'(match_count), 0);
    chk("rstmid_outputs", int'({match_idx, match_pos_a, match_pos_b}), 0);
    chk("rstmid_no_done", done_cnt, 0);
    step();
    rst_n = 1'b1;
    a_q.delete();
    b_q.delete();
    match_ready = 1'b1;
    step();
    a_q = '{4};
    b_q = '{4};
    expect_match(4, 0, 0);
    pulse_start();
    finish_run("after_rst", 1);

    a_q = '{1, 2, 3, 6};
    b_q = '{6};
    expect_match(6, 3, 0);
    pulse_start();
    step();
    chk("busy_mid_run", int'(busy), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    finish_run("start_busy", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/index_intersect_ctrl.md
Name: index_intersect_ctrl

Overview:
- Sequences one shared `comparator` instance to intersect two ascending-sorted sparse index streams (A: row nonzeros, B: column nonzeros) for the SpMM datapath.
- Compares the stream heads, advances the smaller head, and emits each matching index with its 0-based positions in both streams.
- Drains the remaining stream after the other ends, then pulses `done`. The match output feeds the MAC operand fetch.

Parameters:
- data_width_param, 4, width of index values and of the comparator.
- pos_width_param, 8, width of position counters and of `match_count`.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begins a run from IDLE
- a_valid  in  1  A head valid
- a_ready  out  1  A head consumed this cycle
- a_idx  in  data_width_param  A head index
- a_last  in  1  A head is the final element
- b_valid  in  1  B head valid
- b_ready  out  1  B head consumed this cycle
- b_idx  in  data_width_param  B head index
- b_last  in  1  B head is the final element
- match_valid  out  1  registered match available
- match_ready  in  1  downstream accepts match
- match_idx  out  data_width_param  matched index
- match_pos_a  out  pos_width_param  position of match in A
- match_pos_b  out  pos_width_param  position of match in B
- match_count  out  pos_width_param  matches in current run
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is `clk`, reset port is `rst_n`.
- Reset: state=IDLE; all counters 0; all outputs 0.
- A reset mid-run aborts immediately. Any pending match is dropped and no `done` is issued. Upstream holds its heads.
- States: IDLE, RUN, DRAIN_A, DRAIN_B, FLUSH.
- IDLE:
  - `a_ready` = `b_ready` = 0.
  - `start` clears pos_a, pos_b and `match_count`, then goes to RUN.
  - `start` in any other state is ignored.
- Comparator connections: d0=`a_idx`, d1_ref=`b_idx`. The result is used only in RUN, with `a_valid` && `b_valid`, in the same cycle (combinational).
- RUN, LT:
  - `a_ready`=1; pos_a++.
  - If `a_last`: go to DRAIN_B.
- RUN, GT:
  - `b_ready`=1; pos_b++.
  - If `b_last`: go to DRAIN_A.
- RUN, EQ:
  - Proceeds only if the output slot is free, i.e. (!`match_valid` || `match_ready`). Otherwise stall with both readies 0.
  - When proceeding: `a_ready` = `b_ready` = 1.
  - Next cycle: `match_valid`=1, `match_idx`=`a_idx`, `match_pos_a`/`match_pos_b` = pre-increment pos_a/pos_b.
  - pos_a++, pos_b++, `match_count`++ (saturating at all-ones).
  - Next state: both last → FLUSH; `a_last` only → DRAIN_B; `b_last` only → DRAIN_A.
- RUN with either valid low: no action, readies 0.
- DRAIN_A / DRAIN_B:
  - `x_ready`=`x_valid`; consume and discard, posX++.
  - On a consumed `x_last`: go to FLUSH.
- FLUSH: wait until `match_valid`==0. Then assert `done` for one cycle and go to IDLE.
- Output slot: 1-entry register. Latency is 1 cycle from EQ consume to `match_valid`.
  - `match_valid` clears on `match_ready` unless a new EQ loads in the same cycle; a new load takes priority.
  - Outputs are held stable while `match_valid` && !`match_ready`.
- Position counters wrap modulo 2^pos_width_param. Longer streams are unsupported.
- Each stream carries at least one element per run.
- `busy` = (state != IDLE).

Decomposition:
- Package `spmm_pkg`:
  - Comparator encoding constants COMP_LT, COMP_EQ, COMP_GT (the 2-bit `comparator_out` codes).
  - State enum `isect_state_t`.
  - Default width constants.
- Sub-module: the existing `comparator`, instantiated once with data_width_param. No new sub-module.

Test Plan (data_width_param=4):
- Basic intersection: A={1,3,5,9}, B={3,4,9,11}, `match_ready`=1.
  - Matches (idx3, pos_a1, pos_b0) and (idx9, pos_a3, pos_b2).
  - 11 is drained; `done` pulses once; `match_count`=2.
- Disjoint streams: A={0,2}, B={8,15}.
  - No matches; A consumed, B drained; `done` pulses; `match_count`=0.
- Backpressure: A={11,15}, B={11,15}, with `match_ready` held 0 for 3 cycles after the first match.
  - idx11 is held stable; both readies stay 0 at head 15; stall released when `match_ready`=1; second match at (pos 1,1); `done` follows the final drain.
- Simultaneous last: A={9}, B={9}.
  - A single match at (0,0), then FLUSH, then `done` after the match is accepted.
- Reset mid-run: assert `rst_n`=0 while a match is pending.
  - Next cycle: all outputs 0 and state IDLE; no `done`.
  - A following `start` runs cleanly from pos 0.
- Start while busy: a `start` pulse during RUN is ignored and counters are not cleared.
